pico_spi_rx: RTL and testbench

Receives 16-bit audio samples from the Pico over a 3-wire SPI link (SCLK, MOSI, active-high CS) and presents each complete word to the bypass/effect mux and `dac_driver` as a parallel sample with a one-cycle strobe. It sits directly downstream of the board pins and upstream of the mux in `top`. The block oversamples the SPI link in the 25 MHz system domain, with no second clock. Malformed frames are discarded and flagged.

---
 rtl/pedal_pkg.sv | 20 ++
 rtl/pico_spi_rx_sync_ff.sv | 27 ++
 rtl/pico_spi_rx.sv | 190 +++++++++++++++++++
 tb/tb_pico_spi_rx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pedal_pkg.sv
// Shared types and constants for the pedal audio path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pedal_pkg;

    // Audio sample width used across the pedal datapath.
    localparam int AUDIO_W = 16;

    // Default depth of the input synchronizer chains.
    localparam int SYNC_STAGES_DEF = 2;

    // Receiver control states.
    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        FULL      = 2'd3
    } spi_rx_state_t;

endpackage

// File: rtl/pico_spi_rx_sync_ff.sv
// Multi-stage flip-flop synchronizer for one asynchronous input bit.
// Latency: STAGES clock edges from pin to q.
// Backpressure: none; a level is sampled every cycle.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the sampled pin level through the chain; oldest sample is the output.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pico_spi_rx.sv
// Oversampled 3-wire SPI receiver delivering one DATA_W-bit audio word per CS frame.
// Latency: strobe on the edge after the synchronized DATA_W-th SCLK rise (SYNC_STAGES+1 edges from pin sample).
// Backpressure: none; consumer must take audio_out on data_is_ready, no buffering.
module pico_spi_rx
    import pedal_pkg::*;
#(
    parameter int DATA_W      = AUDIO_W,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk_25mhz,
    input  logic              reset,
    input  logic              com_sclk_in,
    input  logic              com_mosi_in,
    input  logic              com_active,
    output logic [DATA_W-1:0] audio_out,
    output logic              data_is_ready,
    output logic              frame_error
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam int FL_W  = $clog2(SYNC_STAGES + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [FL_W-1:0]  FL_ONE   = FL_W'(1);
    localparam logic [FL_W-1:0]  FL_DONE  = FL_W'(SYNC_STAGES);

    // Synchronized pin levels.
    logic sclk_s;
    logic mosi_s;
    logic cs_s;

    // One-cycle-delayed copies for edge detection.
    logic sclk_q;
    logic cs_q;

    logic sclk_rise;
    logic cs_rise;
    logic cs_fall;

    // Cycles spent in WAIT_IDLE since reset; the CS chain is only trusted once
    // it holds post-reset pin samples end to end.
    logic [FL_W-1:0] flush_cnt;
    logic            flushed;

    spi_rx_state_t     state;
    spi_rx_state_t     state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_cnt_nxt;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_nxt;
    logic [DATA_W-1:0] shift_in;
    logic              overflow;
    logic              overflow_nxt;
    logic [DATA_W-1:0] audio_nxt;
    logic              ready_nxt;
    logic              error_nxt;

    // MOSI shares the SCLK chain depth so a bit stays aligned with its clock edge.
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk   (clk_25mhz),
        .reset (reset),
        .d     (com_sclk_in),
        .q     (sclk_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk   (clk_25mhz),
        .reset (reset),
        .d     (com_mosi_in),
        .q     (mosi_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
        .clk   (clk_25mhz),
        .reset (reset),
        .d     (com_active),
        .q     (cs_s)
    );

    // Delay the synchronized levels one cycle to form edge strobes.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            sclk_q <= 1'b0;
            cs_q   <= 1'b0;
        end else begin
            sclk_q <= sclk_s;
            cs_q   <= cs_s;
        end
    end

    // CS edges are masked while waiting out reset so a reset-cleared chain
    // filling with a high pin level cannot look like a new frame.
    assign sclk_rise = sclk_s & ~sclk_q;
    assign cs_rise   = cs_s & ~cs_q & (state != WAIT_IDLE);
    assign cs_fall   = ~cs_s & cs_q & (state != WAIT_IDLE);
    assign flushed   = (flush_cnt == FL_DONE);
    assign shift_in  = {shift_reg[DATA_W-2:0], mosi_s};

    // Count cycles after reset until the CS synchronizer has refilled.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            flush_cnt <= '0;
        end else if ((state == WAIT_IDLE) && !flushed) begin
            flush_cnt <= flush_cnt + FL_ONE;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state         <= WAIT_IDLE;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            overflow      <= 1'b0;
            audio_out     <= '0;
            data_is_ready <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            state         <= state_nxt;
            bit_cnt       <= bit_cnt_nxt;
            shift_reg     <= shift_nxt;
            overflow      <= overflow_nxt;
            audio_out     <= audio_nxt;
            data_is_ready <= ready_nxt;
            frame_error   <= error_nxt;
        end
    end

    // Frame sequencing: CS fall takes priority over a coincident SCLK rise.
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        shift_nxt    = shift_reg;
        overflow_nxt = overflow;
        audio_nxt    = audio_out;
        ready_nxt    = 1'b0;
        error_nxt    = 1'b0;

        case (state)
            WAIT_IDLE: begin
                if (flushed && !cs_s) begin
                    state_nxt = IDLE;
                end
            end

            IDLE: begin
                if (cs_rise) begin
                    bit_cnt_nxt  = '0;
                    shift_nxt    = '0;
                    overflow_nxt = 1'b0;
                    state_nxt    = SHIFT;
                end
            end

            SHIFT: begin
                if (cs_fall) begin
                    // A partial word is dropped; an empty frame is not an error.
                    error_nxt = (bit_cnt != CNT_ZERO);
                    state_nxt = IDLE;
                end else if (sclk_rise) begin
                    shift_nxt   = shift_in;
                    bit_cnt_nxt = bit_cnt + CNT_ONE;
                    if (bit_cnt == CNT_LAST) begin
                        audio_nxt = shift_in;
                        ready_nxt = 1'b1;
                        state_nxt = FULL;
                    end
                end
            end

            FULL: begin
                if (cs_fall) begin
                    // The word already delivered stands; only the excess is flagged.
                    error_nxt    = overflow;
                    overflow_nxt = 1'b0;
                    state_nxt    = IDLE;
                end else if (sclk_rise) begin
                    overflow_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = WAIT_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pico_spi_rx.sv
// Directed bench for pico_spi_rx with a queue-based strobe scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_pico_spi_rx;

    localparam int W = 16;

    logic         tb_clk_25mhz = 1'b0;
    logic         reset        = 1'b1;
    logic         com_sclk_in  = 1'b0;
    logic         com_mosi_in  = 1'b0;
    logic         com_active   = 1'b0;
    logic [W-1:0] audio_out;
    logic         data_is_ready;
    logic         frame_error;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic         is_err;
        logic [W-1:0] val;
    } exp_t;

    exp_t exp_q[$];

    pico_spi_rx #(.DATA_W(W), .SYNC_STAGES(2)) dut (
        .clk_25mhz     (tb_clk_25mhz),
        .reset         (reset),
        .com_sclk_in   (com_sclk_in),
        .com_mosi_in   (com_mosi_in),
        .com_active    (com_active),
        .audio_out     (audio_out),
        .data_is_ready (data_is_ready),
        .frame_error   (frame_error)
    );

    // 25 MHz system clock.
    always #20 tb_clk_25mhz = ~tb_clk_25mhz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every strobe consumes the oldest expected event.
    always @(negedge tb_clk_25mhz) begin
        if (data_is_ready || frame_error) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {30'b0, data_is_ready, frame_error}, 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_kind", {30'b0, data_is_ready, frame_error},
                      e.is_err ? 32'h1 : 32'h2);
                if (!e.is_err) begin
                    check("sample", {16'b0, audio_out}, {16'b0, e.val});
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge tb_clk_25mhz);
    endtask

    task automatic expect_word(input logic [W-1:0] v);
        exp_t e;
        e.is_err = 1'b0;
        e.val    = v;
        exp_q.push_back(e);
    endtask

    task automatic expect_error();
        exp_t e;
        e.is_err = 1'b1;
        e.val    = '0;
        exp_q.push_back(e);
    endtask

    task automatic cs_up();
        com_active = 1'b1;
        cycles(3);
    endtask

    // Nominal ~2 MHz SCLK: 6 cycles low, 6 high, MOSI set 3 cycles before the rise.
    task automatic send_bits(input logic [31:0] w, input int n, input bit cs_with_last);
        for (int i = 0; i < n; i++) begin
            com_mosi_in = w[n-1-i];
            cycles(3);
            com_sclk_in = 1'b1;
            if (cs_with_last && (i == n - 1)) begin
                com_active = 1'b0;
            end
            cycles(6);
            com_sclk_in = 1'b0;
            cycles(3);
        end
    endtask

    task automatic cs_down(input int gap);
        cycles(3);
        com_active = 1'b0;
        cycles(gap);
    endtask

    task automatic frame(input logic [31:0] w, input int n);
        cs_up();
        send_bits(w, n, 1'b0);
        cs_down(8);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            cycles(1);
        end
        check(name, exp_q.size(), 32'h0);
        exp_q.delete();
    endtask

    // Hard stop if the sequence ever stalls.
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed sequence.
    initial begin
        reset = 1'b1;
        cycles(5);
        check("reset_audio", {16'b0, audio_out}, 32'h0);
        check("reset_ready", {31'b0, data_is_ready}, 32'h0);
        check("reset_error", {31'b0, frame_error}, 32'h0);
        reset = 1'b0;
        cycles(6);

        // Single word.
        expect_word(16'hC0DE);
        frame(32'hC0DE, 16);
        drain("word_drain");
        check("word_hold", {16'b0, audio_out}, 32'h0000C0DE);

        // Back-to-back with a 4-cycle CS gap.
        expect_word(16'h0001);
        expect_word(16'hFFFF);
        cs_up();
        send_bits(32'h0001, 16, 1'b0);
        cs_down(4);
        cs_up();
        send_bits(32'hFFFF, 16, 1'b0);
        cs_down(8);
        drain("b2b_drain");
        check("b2b_hold", {16'b0, audio_out}, 32'h0000FFFF);

        // Short frame after a good word.
        expect_word(16'h1234);
        frame(32'h1234, 16);
        expect_error();
        frame(32'h00A5, 8);
        drain("short_drain");
        check("short_hold", {16'b0, audio_out}, 32'h00001234);

        // Long frame: 16 good bits then 2 extra.
        expect_word(16'hBEEF);
        expect_error();
        frame({14'b0, 16'hBEEF, 2'b11}, 18);
        drain("long_drain");
        check("long_hold", {16'b0, audio_out}, 32'h0000BEEF);

        // Reset mid-frame, CS still high at release.
        cs_up();
        send_bits(32'h55, 7, 1'b0);
        cycles(2);
        reset = 1'b1;
        cycles(4);
        check("midrst_audio", {16'b0, audio_out}, 32'h0);
        reset = 1'b0;
        cycles(3);
        send_bits(32'h1AB, 9, 1'b0);
        cs_down(10);
        check("midrst_between", {16'b0, audio_out}, 32'h0);
        check("midrst_nostrobe", exp_q.size(), 32'h0);
        expect_word(16'hA5A5);
        frame(32'hA5A5, 16);
        drain("midrst_drain");
        check("midrst_hold", {16'b0, audio_out}, 32'h0000A5A5);

        // 16th SCLK rise and CS fall reach the synchronizers together.
        expect_error();
        cs_up();
        send_bits(32'h1357, 16, 1'b1);
        cycles(10);
        drain("coinc_drain");
        check("coinc_hold", {16'b0, audio_out}, 32'h0000A5A5);

        // Receiver still healthy afterwards.
        expect_word(16'h8001);
        frame(32'h8001, 16);
        drain("recover_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
